// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam logic [31:0] ERR_DATA     = 32'h0000_0000;
    localparam int          CNT_W        = 4;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x 32 instruction storage, one write port, one registered read port
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    // Read and write share one block so a same-edge write to the read word returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding fixed-latency instruction fetch responder
module imem_responder
    import imem_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 256,
    parameter int               LATENCY = 2,
    parameter logic [WIDTH-1:0] BASE    = WIDTH'(DEFAULT_BASE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] addr_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;

    logic [WIDTH-1:0] word_idx;
    logic             addr_err;
    logic             enter_resp;
    logic [31:0]      rd_data;

    assign word_idx   = (addr_q - BASE) >> 2;
    assign addr_err   = (addr_q[1:0] != 2'b00) || (word_idx >= WIDTH'(DEPTH));
    assign enter_resp = (state_q == WAIT) && (cnt_q == '0);

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (enter_resp),
        .rd_addr (word_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    // Every accept passes through WAIT (count LATENCY-1 down to 0), so resp_valid
    // rises exactly LATENCY edges after the accept for any LATENCY, including 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        cnt_q       <= LAT_LOAD;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= addr_err;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = (resp_valid_q && !resp_err_q) ? rd_data : ERR_DATA;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder (LATENCY 2 and LATENCY 1 instances)
module tb_imem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic        resp_err   [2];
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    imem_responder #(.LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        int          w;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   acc_cyc   [2];
    logic prev_valid[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accept timestamps, response latency and scoreboard compare
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (rst && req_valid[w] && req_ready[w]) acc_cyc[w] = cyc + 1;
            if (resp_valid[w] && !prev_valid[w])
                check($sformatf("latency%0d", w), cyc - acc_cyc[w], (w == 0) ? 2 : 1);
            if (resp_valid[w] && resp_ready[w]) begin
                if (sb.size() == 0 || sb[0].w != w) begin
                    check($sformatf("unexpected_resp%0d", w), 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("data%0d", w), resp_data[w], e.data);
                    check($sformatf("err%0d", w), resp_err[w], e.err);
                end
            end
            prev_valid[w] = resp_valid[w];
        end
    end

    task automatic write_word(input logic [7:0] idx, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = idx; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic issue(input int w, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, input bit expect_resp, output int acc_edge);
        req_valid[w] = 1'b1;
        req_addr[w]  = addr;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[w]) begin
                if (expect_resp) sb.push_back('{w, data, err});
                @(posedge clk); #1;
                req_valid[w] = 1'b0;
                acc_edge = cyc;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        req_valid[w] = 1'b0;
        acc_edge = cyc;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
    endtask

    localparam int NV = 6;
    logic [31:0] v_addr [NV] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_03FC,
                                 32'h8000_0002, 32'h8000_0400, 32'h7FFF_FFFC};
    logic [31:0] v_data [NV] = '{32'h0000_0413, 32'h00A0_0093, 32'hDEAD_BEEF,
                                 32'h0, 32'h0, 32'h0};
    logic        v_err  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int e0, e1, seen;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int w = 0; w < 2; w++) begin
            req_valid[w] = 1'b0; req_addr[w] = '0; resp_ready[w] = 1'b1;
            acc_cyc[w] = 0; prev_valid[w] = 1'b0;
        end
        repeat (2) @(posedge clk); #1;
        write_word(8'd0,   32'h0000_0413);
        write_word(8'd1,   32'h00A0_0093);
        write_word(8'd2,   32'h0010_8113);
        write_word(8'd255, 32'hDEAD_BEEF);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("rst_valid%0d", w), resp_valid[w], 0);
            check($sformatf("rst_data%0d", w), resp_data[w], 0);
            check($sformatf("rst_err%0d", w), resp_err[w], 0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst0", req_ready[0], 1);
        check("ready_after_rst1", req_ready[1], 1);
        @(posedge clk); #1;

        // Basic fetch: ready returns three edges after accept
        issue(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 1, e0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        check("ready_back", cyc - e0, 3);
        drain();

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            issue(0, v_addr[i], v_data[i], v_err[i], 1, e0);
            drain();
        end

        // Stalled response held while the same word is rewritten
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        issue(0, 32'h8000_0004, 32'h00A0_0093, 1'b0, 1, e0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid[0]) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wr_en = (i == 0); wr_addr = 8'd1; wr_data = 32'h1234_5678;
            @(negedge clk);
            check("hold_data", resp_data[0], 32'h00A0_0093);
            check("hold_ready", req_ready[0], 0);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; resp_ready[0] = 1'b1;
        drain();
        @(posedge clk); #1;
        issue(0, 32'h8000_0004, 32'h1234_5678, 1'b0, 1, e0);
        drain();

        // Write on the RESP-entry edge is not visible to that response
        @(posedge clk); #1;
        issue(0, 32'h8000_0008, 32'h0010_8113, 1'b0, 1, e0);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        wr_en = 1'b0;
        drain();
        @(posedge clk); #1;
        issue(0, 32'h8000_0008, 32'hCAFE_0001, 1'b0, 1, e0);
        drain();

        // Reset one cycle after accept aborts the transaction
        @(posedge clk); #1;
        issue(0, 32'h8000_0000, 32'h0, 1'b0, 0, e0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rst_valid", resp_valid[0], 0);
        @(posedge clk); #1 rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        check("abort_no_resp", seen, 0);
        check("abort_ready", req_ready[0], 1);
        @(posedge clk); #1;
        issue(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 1, e0);
        drain();

        // LATENCY=1 instance, back-to-back requests
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        issue(1, 32'h8000_0000, 32'h0000_0413, 1'b0, 1, e0);
        issue(1, 32'h8000_0004, 32'h1234_5678, 1'b0, 1, e1);
        check("b2b_gap", e1 - e0, 3);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
